// File: rtl/wb_port_arbiter.sv
// Register-file write-back arbiter: ALU > load > one-entry mul/div buffer, grants combinational, buffer write-back >= 1 cycle after MdValid.
// Define WB_STARVE_GUARD_EN to force the buffer through after STARVE_LIMIT consecutive lost cycles.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   AluValid,
  input  logic [4:0]             AluRd,
  output logic                   AluReady,
  input  logic                   LoadValid,
  input  logic [4:0]             LoadRd,
  output logic                   LoadReady,
  input  logic                   MdValid,
  input  logic [4:0]             MdRd,
  input  logic [`DATA_WIDTH-1:0] MdData,
  output logic                   MdReady,
  output logic [`DATA_WIDTH-1:0] MdBufData,
  output logic [1:0]             WbSelect,
  output logic                   WbEn,
  output logic [4:0]             WbRd
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t             r_state;
  buf_state_t             w_state_nxt;
  logic [4:0]             r_md_rd;
  logic [`DATA_WIDTH-1:0] r_md_data;
  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_grant2;
  logic                   w_capture;
  logic                   w_guard;

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == EMPTY || w_grant2) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CW'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  assign w_guard = (r_state == FULL) && (r_starve_cnt == CW'(STARVE_LIMIT));
`else
  // Pure fixed priority: the guard can never fire.
  assign w_guard = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    w_grant2 = 1'b0;
    if (Rst_n) begin
      if (w_guard) begin
        w_grant2 = 1'b1;
      end else if (AluValid) begin
        w_grant0 = 1'b1;
      end else if (LoadValid) begin
        w_grant1 = 1'b1;
      end else if (r_state == FULL) begin
        w_grant2 = 1'b1;
      end
    end
  end

  assign AluReady  = w_grant0;
  assign LoadReady = w_grant1;
  assign MdReady   = Rst_n && (r_state == EMPTY || w_grant2);
  assign w_capture = MdValid && MdReady;
  assign MdBufData = r_md_data;

  always_comb begin
    WbSelect = 2'b00;
    WbRd     = 5'd0;
    if (w_grant0) begin
      WbRd = AluRd;
    end else if (w_grant1) begin
      WbSelect = 2'b01;
      WbRd     = LoadRd;
    end else if (w_grant2) begin
      WbSelect = 2'b10;
      WbRd     = r_md_rd;
    end
  end

  // x0 writes are still consumed; only the register-file strobe is suppressed.
  assign WbEn = (w_grant0 || w_grant1 || w_grant2) && (WbRd != 5'd0);

  always_comb begin
    w_state_nxt = r_state;
    if (w_capture) begin
      w_state_nxt = FULL;
    end else if (w_grant2) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_md_rd   <= 5'd0;
      r_md_data <= '0;
    end else if (w_capture) begin
      r_md_rd   <= MdRd;
      r_md_data <= MdData;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: driver queues hand-computed expectations, negedge monitor compares.
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic        AluValid;
  logic [4:0]  AluRd;
  logic        AluReady;
  logic        LoadValid;
  logic [4:0]  LoadRd;
  logic        LoadReady;
  logic        MdValid;
  logic [4:0]  MdRd;
  logic [31:0] MdData;
  logic        MdReady;
  logic [31:0] MdBufData;
  logic [1:0]  WbSelect;
  logic        WbEn;
  logic [4:0]  WbRd;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .AluValid(AluValid), .AluRd(AluRd), .AluReady(AluReady),
    .LoadValid(LoadValid), .LoadRd(LoadRd), .LoadReady(LoadReady),
    .MdValid(MdValid), .MdRd(MdRd), .MdData(MdData), .MdReady(MdReady),
    .MdBufData(MdBufData), .WbSelect(WbSelect), .WbEn(WbEn), .WbRd(WbRd)
  );

  typedef struct packed {
    logic        ar;
    logic        lr;
    logic        mr;
    logic [1:0]  sel;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] bd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{AluReady, LoadReady, MdReady, WbSelect, WbEn, WbRd, MdBufData};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got ar=%b lr=%b mr=%b sel=%b en=%b rd=%0d bd=%h, want ar=%b lr=%b mr=%b sel=%b en=%b rd=%0d bd=%h",
                 nm, a.ar, a.lr, a.mr, a.sel, a.en, a.rd, a.bd,
                 e.ar, e.lr, e.mr, e.sel, e.en, e.rd, e.bd);
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      assert (!(MdValid && !MdReady))
        else $error("FAIL md_handshake: MdValid=1 while MdReady=0");
    end
  end

  task automatic step(input string nm,
                      input logic av, input logic [4:0] ard,
                      input logic lv, input logic [4:0] lrd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic ar, input logic lr, input logic mr,
                      input logic [1:0] sel, input logic en, input logic [4:0] rd,
                      input logic [31:0] bd);
    AluValid  = av;  AluRd  = ard;
    LoadValid = lv;  LoadRd = lrd;
    MdValid   = mv;  MdRd   = mrd;  MdData = mdat;
    exp_q.push_back('{ar, lr, mr, sel, en, rd, bd});
    name_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n = 1'b0;
    AluValid = 0; AluRd = 0; LoadValid = 0; LoadRd = 0;
    MdValid = 0; MdRd = 0; MdData = 0;
    @(posedge Clk);
    #1;
    //   name          av ard  lv lrd  mv mrd mdat            ar lr mr sel    en rd  bd
    step("rst_hold",   0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 0, 2'b00, 0, 0,  32'h0);
    Rst_n = 1'b1;
    step("md_cap5",    0, 0,   0, 0,   1, 5,  32'h1234,       0, 0, 1, 2'b00, 0, 0,  32'h0);
    Rst_n = 1'b0;
    step("rst_full",   0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 0, 2'b00, 0, 0,  32'h0);
    Rst_n = 1'b1;
    step("post_rst",   0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b00, 0, 0,  32'h0);
    step("alu_ld",     1, 3,   1, 4,   0, 0,  32'h0,          1, 0, 1, 2'b00, 1, 3,  32'h0);
    step("ld_only",    0, 0,   1, 4,   0, 0,  32'h0,          0, 1, 1, 2'b01, 1, 4,  32'h0);
    step("md_pulse7",  0, 0,   0, 0,   1, 7,  32'hDEADBEEF,   0, 0, 1, 2'b00, 0, 0,  32'h0);
    step("md_wb7",     0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b10, 1, 7,  32'hDEADBEEF);
    step("md_empty",   0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b00, 0, 0,  32'hDEADBEEF);
    step("alu_x0",     1, 0,   0, 0,   0, 0,  32'h0,          1, 0, 1, 2'b00, 0, 0,  32'hDEADBEEF);
    step("st_cap",     1, 1,   0, 0,   1, 12, 32'hCAFE,       1, 0, 1, 2'b00, 1, 1,  32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      if (GUARD && i == 4)
        step($sformatf("starve_%0d", i), 1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b10, 1, 12, 32'hCAFE);
      else
        step($sformatf("starve_%0d", i), 1, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0, 2'b00, 1, 1,  32'hCAFE);
    end
    if (GUARD)
      step("starve_end", 0, 0, 0, 0, 0, 0, 32'h0,             0, 0, 1, 2'b00, 0, 0,  32'hCAFE);
    else
      step("starve_end", 0, 0, 0, 0, 0, 0, 32'h0,             0, 0, 1, 2'b10, 1, 12, 32'hCAFE);
    step("dr_cap9",    1, 2,   0, 0,   1, 9,  32'h99,         1, 0, 1, 2'b00, 1, 2,  32'hCAFE);
    step("dr_refill",  0, 0,   0, 0,   1, 10, 32'h55,         0, 0, 1, 2'b10, 1, 9,  32'h99);
    step("dr_next",    0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b10, 1, 10, 32'h55);
    step("ld_md0",     0, 0,   1, 6,   1, 0,  32'h77,         0, 1, 1, 2'b01, 1, 6,  32'h55);
    step("md_x0",      0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b10, 0, 0,  32'h77);
    step("idle",       0, 0,   0, 0,   0, 0,  32'h0,          0, 0, 1, 2'b00, 0, 0,  32'h77);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
